// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared constants and types for the ID/EX stage: datapath and
//               register-index widths, ALU opcode encodings, the NOP field set
//               loaded into a bubble slot, and the forwarding-source enum.
// Revision    : 1.0  initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int REG_DATA_BUS = 32;
    localparam int REG_ADDR_BUS = 5;

    // ALU opcode encodings seen by the downstream combinational ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Field values written into the slot when it turns into a bubble
    localparam logic [3:0] NOP_ALU_OP = ALU_ADD;
    localparam logic       NOP_RD_WE  = 1'b0;

    // Which candidate a forwarding mux picked for one source operand
    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_RF   = 2'd3
    } fwd_sel_e;

    // The ALU shifts by the whole operand, so shift ops need a 5-bit shamt
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage : id_ex_stage_pkg
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle of every ID-side, forwarding, control and EX-side
//               signal of the ID/EX stage.
//               master : the surrounding pipeline (drives ID/fwd/control).
//               slave  : the id_ex_stage itself.
// Revision    : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    // ID-side decoded instruction
    logic               id_valid_i;
    logic [XLEN-1:0]    id_pc_i;
    logic [RADDR_W-1:0] id_rs1_addr_i;
    logic [RADDR_W-1:0] id_rs2_addr_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic               id_src1_pc_i;
    logic               id_src2_imm_i;
    logic [3:0]         id_alu_op_i;
    logic [RADDR_W-1:0] id_rd_addr_i;
    logic               id_rd_we_i;
    logic               id_mem_read_i;
    // Forwarding candidates
    logic [RADDR_W-1:0] mem_rd_addr_i;
    logic               mem_rd_we_i;
    logic [XLEN-1:0]    mem_rd_data_i;
    logic [RADDR_W-1:0] wb_rd_addr_i;
    logic               wb_rd_we_i;
    logic [XLEN-1:0]    wb_rd_data_i;
    // Pipeline control
    logic               stall_i;
    logic               flush_i;
    // Stage outputs
    logic               hazard_stall_o;
    logic               ex_valid_o;
    logic [XLEN-1:0]    alu_data1_o;
    logic [XLEN-1:0]    alu_data2_o;
    logic [3:0]         alu_op_o;
    logic [XLEN-1:0]    ex_rs2_fwd_o;
    logic [RADDR_W-1:0] ex_rd_addr_o;
    logic               ex_rd_we_o;
    logic               ex_mem_read_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_src1_pc_i,
               id_src2_imm_i, id_alu_op_i, id_rd_addr_i, id_rd_we_i,
               id_mem_read_i, mem_rd_addr_i, mem_rd_we_i, mem_rd_data_i,
               wb_rd_addr_i, wb_rd_we_i, wb_rd_data_i, stall_i, flush_i,
        input  hazard_stall_o, ex_valid_o, alu_data1_o, alu_data2_o,
               alu_op_o, ex_rs2_fwd_o, ex_rd_addr_o, ex_rd_we_o, ex_mem_read_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_src1_pc_i,
               id_src2_imm_i, id_alu_op_i, id_rd_addr_i, id_rd_we_i,
               id_mem_read_i, mem_rd_addr_i, mem_rd_we_i, mem_rd_data_i,
               wb_rd_addr_i, wb_rd_we_i, wb_rd_data_i, stall_i, flush_i,
        output hazard_stall_o, ex_valid_o, alu_data1_o, alu_data2_o,
               alu_op_o, ex_rs2_fwd_o, ex_rd_addr_o, ex_rd_we_o, ex_mem_read_o
    );

endinterface : id_ex_stage_if
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_fwd_mux
// Description : Forwarding selector for one source operand. Picks the EX/MEM
//               result, then the MEM/WB result, then the registered
//               register-file data; index x0 always yields zero.
// Ports       : rs_addr_i/rf_data_i       registered source index and data
//               mem_rd_*_i / wb_rd_*_i    forwarding candidates
//               fwd_data_o                resolved operand
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  wire logic [RADDR_W-1:0] rs_addr_i,
    input  wire logic [XLEN-1:0]    rf_data_i,
    input  wire logic [RADDR_W-1:0] mem_rd_addr_i,
    input  wire logic               mem_rd_we_i,
    input  wire logic [XLEN-1:0]    mem_rd_data_i,
    input  wire logic [RADDR_W-1:0] wb_rd_addr_i,
    input  wire logic               wb_rd_we_i,
    input  wire logic [XLEN-1:0]    wb_rd_data_i,
    output logic      [XLEN-1:0]    fwd_data_o
);

    fwd_sel_e w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (rs_addr_i == '0) begin
            w_sel = FWD_ZERO;
        end else if (mem_rd_we_i && (mem_rd_addr_i == rs_addr_i)) begin
            // Younger producer wins over MEM/WB
            w_sel = FWD_MEM;
        end else if (wb_rd_we_i && (wb_rd_addr_i == rs_addr_i)) begin
            w_sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_data_o = rf_data_i;
        case (w_sel)
            FWD_ZERO: fwd_data_o = '0;
            FWD_MEM:  fwd_data_o = mem_rd_data_i;
            FWD_WB:   fwd_data_o = wb_rd_data_i;
            default:  fwd_data_o = rf_data_i;
        endcase
    end

endmodule : id_ex_stage_fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with the EX-side operand network.
//               Captures decoded ID fields, resolves EX/MEM and MEM/WB
//               forwarding for both sources, selects PC/immediate operands,
//               masks shift amounts, detects load-use hazards and applies
//               flush/stall/bubble control.
// Ports       : clk, rst (synchronous, active-high)
//               bus : id_ex_stage_if.slave carrying ID inputs, forwarding
//                     candidates, stall/flush and all EX-side outputs.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN    = REG_DATA_BUS,
    parameter int RADDR_W = REG_ADDR_BUS
) (
    input  wire logic     clk,
    input  wire logic     rst,
    id_ex_stage_if.slave  bus
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               valid_q,    valid_d;
    logic [XLEN-1:0]    pc_q,       pc_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic               src1_pc_q,  src1_pc_d;
    logic               src2_imm_q, src2_imm_d;
    logic [3:0]         alu_op_q,   alu_op_d;
    logic [RADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic               rd_we_q,    rd_we_d;
    logic               mem_read_q, mem_read_d;

    logic               w_hazard;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;
    logic [XLEN-1:0]    w_op2;
    logic [XLEN-1:0]    w_alu_data2;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in EX cannot forward to the instruction
    // in ID this cycle. A redirect kills ID anyway, so no hold is needed.
    // ------------------------------------------------------------------
    always_comb begin
        w_hazard = 1'b0;
        if (!bus.flush_i && valid_q && mem_read_q && (rd_addr_q != '0) &&
            bus.id_valid_i &&
            ((rd_addr_q == bus.id_rs1_addr_i) || (rd_addr_q == bus.id_rs2_addr_i))) begin
            w_hazard = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: flush > stall > bubble > normal load
    // ------------------------------------------------------------------
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        src1_pc_d  = src1_pc_q;
        src2_imm_d = src2_imm_q;
        alu_op_d   = alu_op_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        mem_read_d = mem_read_q;

        if (bus.flush_i) begin
            valid_d    = 1'b0;
            rd_we_d    = 1'b0;
            mem_read_d = 1'b0;
        end else if (bus.stall_i) begin
            // hold every field
        end else if (w_hazard) begin
            valid_d    = 1'b0;
            alu_op_d   = NOP_ALU_OP;
            rd_addr_d  = '0;
            rd_we_d    = NOP_RD_WE;
            mem_read_d = 1'b0;
        end else begin
            valid_d    = bus.id_valid_i;
            pc_d       = bus.id_pc_i;
            rs1_addr_d = bus.id_rs1_addr_i;
            rs2_addr_d = bus.id_rs2_addr_i;
            rs1_data_d = bus.id_rs1_data_i;
            rs2_data_d = bus.id_rs2_data_i;
            imm_d      = bus.id_imm_i;
            src1_pc_d  = bus.id_src1_pc_i;
            src2_imm_d = bus.id_src2_imm_i;
            alu_op_d   = bus.id_alu_op_i;
            rd_addr_d  = bus.id_rd_addr_i;
            rd_we_d    = bus.id_rd_we_i;
            mem_read_d = bus.id_mem_read_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            src1_pc_q  <= 1'b0;
            src2_imm_q <= 1'b0;
            alu_op_q   <= ALU_ADD;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            mem_read_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            src1_pc_q  <= src1_pc_d;
            src2_imm_q <= src2_imm_d;
            alu_op_q   <= alu_op_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            mem_read_q <= mem_read_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding network: re-evaluated every cycle, also while stalled,
    // so a held instruction picks up results that retire meanwhile.
    // ------------------------------------------------------------------
    id_ex_stage_fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs1 (
        .rs_addr_i     (rs1_addr_q),
        .rf_data_i     (rs1_data_q),
        .mem_rd_addr_i (bus.mem_rd_addr_i),
        .mem_rd_we_i   (bus.mem_rd_we_i),
        .mem_rd_data_i (bus.mem_rd_data_i),
        .wb_rd_addr_i  (bus.wb_rd_addr_i),
        .wb_rd_we_i    (bus.wb_rd_we_i),
        .wb_rd_data_i  (bus.wb_rd_data_i),
        .fwd_data_o    (w_fwd_rs1)
    );

    id_ex_stage_fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs2 (
        .rs_addr_i     (rs2_addr_q),
        .rf_data_i     (rs2_data_q),
        .mem_rd_addr_i (bus.mem_rd_addr_i),
        .mem_rd_we_i   (bus.mem_rd_we_i),
        .mem_rd_data_i (bus.mem_rd_data_i),
        .wb_rd_addr_i  (bus.wb_rd_addr_i),
        .wb_rd_we_i    (bus.wb_rd_we_i),
        .wb_rd_data_i  (bus.wb_rd_data_i),
        .fwd_data_o    (w_fwd_rs2)
    );

    // ------------------------------------------------------------------
    // Operand select and shift-amount masking
    // ------------------------------------------------------------------
    always_comb begin
        w_op2       = src2_imm_q ? imm_q : w_fwd_rs2;
        w_alu_data2 = w_op2;
        if (is_shift_op(alu_op_q)) begin
            w_alu_data2      = '0;
            w_alu_data2[4:0] = w_op2[4:0];
        end
    end

    assign bus.hazard_stall_o = w_hazard;
    assign bus.ex_valid_o     = valid_q;
    assign bus.alu_data1_o    = src1_pc_q ? pc_q : w_fwd_rs1;
    assign bus.alu_data2_o    = w_alu_data2;
    assign bus.alu_op_o       = alu_op_q;
    assign bus.ex_rs2_fwd_o   = w_fwd_rs2;
    assign bus.ex_rd_addr_o   = rd_addr_q;
    // An empty slot must never write back or start a load
    assign bus.ex_rd_we_o     = valid_q & rd_we_q;
    assign bus.ex_mem_read_o  = valid_q & mem_read_q;

endmodule : id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand network for the RV32I core.
- Captures decoded instruction fields from ID and resolves forwarding from the EX/MEM and MEM/WB stages.
- Selects PC/immediate sources and presents final operands and a 4-bit ALU opcode to the combinational ALU.
- Detects load-use hazards, handles stall/flush, and carries rd/write-enable/load flags downstream.

Parameters:
- XLEN, 32, datapath width (matches `REG_DATA_BUS).
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_valid_i  in  1  ID holds a valid instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_addr_i / id_rs2_addr_i  in  RADDR_W  source indices
- id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_src1_pc_i  in  1  operand1 = PC (AUIPC/JAL)
- id_src2_imm_i  in  1  operand2 = immediate
- id_alu_op_i  in  4  ALU opcode (`ALU_* encodings)
- id_rd_addr_i  in  RADDR_W  destination index
- id_rd_we_i  in  1  writes rd
- id_mem_read_i  in  1  instruction is a load
- mem_rd_addr_i / mem_rd_we_i / mem_rd_data_i  in  RADDR_W/1/XLEN  EX/MEM result for forwarding
- wb_rd_addr_i / wb_rd_we_i / wb_rd_data_i  in  RADDR_W/1/XLEN  MEM/WB result for forwarding
- stall_i  in  1  downstream stall; freeze stage
- flush_i  in  1  branch/jump redirect; kill stage contents
- hazard_stall_o  out  1  load-use hazard; ID and IF must hold
- ex_valid_o  out  1  EX holds a live instruction
- alu_data1_o / alu_data2_o  out  XLEN  final ALU operands
- alu_op_o  out  4  opcode to ALU
- ex_rs2_fwd_o  out  XLEN  forwarded rs2 (store data)
- ex_rd_addr_o / ex_rd_we_o / ex_mem_read_o  out  RADDR_W/1/1  carried to EX/MEM

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Registers go to valid=0, pc=0, rs data=0, imm=0, alu_op=`ALU_ADD, rd=0, rd_we=0, mem_read=0.
  - Outputs therefore read: ex_valid_o=0, alu_data1/2=0, rd_we/mem_read=0, hazard_stall_o=0.
- Update priority at posedge: rst > flush_i > stall_i > load-use bubble > normal load.
  - flush_i: valid, rd_we and mem_read cleared; a flush wins even when stall_i=1.
  - stall_i: all registers hold.
  - Bubble: hazard_stall_o=1 and no stall; register loads NOP (valid=0, rd_we=0, mem_read=0).
  - Normal: capture all id_* fields; valid=id_valid_i.
- Latency: one cycle from ID inputs to registered fields. Operands are combinational from registered fields plus the mem_/wb_ inputs in the same cycle.
- hazard_stall_o (combinational) = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid_i & (ex_rd==id_rs1 | ex_rd==id_rs2). It is asserted regardless of stall_i and gated low by flush_i.
- Forwarding, evaluated per source rsN:
  - If mem_rd_we_i & mem_rd_addr_i==rsN & rsN≠0, use mem_rd_data_i.
  - Else if wb_rd_we_i & wb_rd_addr_i==rsN & rsN≠0, use wb_rd_data_i.
  - Else use the registered rf data. EX/MEM has priority; x0 always reads 0.
  - Forwarding is re-evaluated every cycle, including while stalled.
- Operand select:
  - alu_data1_o = src1_pc ? pc : fwd_rs1.
  - alu_data2_o = src2_imm ? imm : fwd_rs2.
  - ex_rs2_fwd_o = fwd_rs2 always.
- Shift masking: when alu_op is `ALU_SLL/`ALU_SRL/`ALU_SRA, alu_data2_o = {27'b0, operand2[4:0]}. The ALU shifts by the full operand, so this stage enforces the 5-bit shamt.
- Invalid slot: ex_valid_o=0 forces ex_rd_we_o=0 and ex_mem_read_o=0. Operands may be don't-care.

Decomposition:
- Shared defines/package holds:
  - `ALU_* opcode constants, `REG_DATA_BUS, `REG_ADDR_BUS.
  - A NOP constant set: alu_op=`ALU_ADD, rd=0, we=0.
- One sub-module, fwd_mux: one forwarding source (rs index, rf data, mem/wb candidates → data). Instantiate it twice.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid_i=1 → ex_valid_o=0, ex_rd_we_o=0, alu_data1_o=0, hazard_stall_o=0.
- Forwarding:
  - EX/MEM priority: rs1=5, rf=0x11, mem rd=5 data=0xAAAA0000, wb rd=5 data=0x5555 → alu_data1_o=0xAAAA0000.
  - Drop mem_rd_we_i → 0x5555.
  - rs1=0 with mem rd=0 we=1 → 0.
- Load-use: EX holds a load rd=7; ID valid with rs2=7 → hazard_stall_o=1. Next cycle ex_valid_o=0 and ex_rd_we_o=0. Instruction captured the following cycle once the hazard clears.
- Stall/flush:
  - stall_i=1 for 3 cycles while ID changes → registered pc/rd unchanged.
  - stall_i=1 with flush_i=1 → ex_valid_o=0 next cycle.
- Shift mask: alu_op=`ALU_SLL, src2_imm=1, imm=0x0000_0423 → alu_data2_o=0x3.
- Operand select: src1_pc=1, pc=0x8000_0010, src2_imm=1, imm=0xFFFF_F000 → alu_data1_o=0x80000010, alu_data2_o=0xFFFFF000.
